// File: rtl/ula_op_sequencer.sv
// Command/operand sequencer for the 6-bit ULA: accepts one operation per handshake,
// drives the ULA for one stable cycle, captures its result and presents it downstream.
module ula_op_sequencer #(
    parameter int WIDTH = 6,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [3:0]       in_op,
    input  logic             in_chain,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic             alu_mode,
    output logic [2:0]       alu_oper,
    output logic             alu_reset,
    input  logic [WIDTH-1:0] alu_o,
    input  logic             alu_overflow,
    input  logic             alu_zero,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] res_o,
    output logic             res_overflow,
    output logic             res_zero,
    output logic             sticky_ovf,
    input  logic             clear_sticky,
    output logic [CNT_W-1:0] op_count
);

    typedef enum logic [1:0] {IDLE, DRIVE, CAPTURE, DONE} state_t;

    state_t           state_q;
    logic             in_ready_q;
    logic             out_valid_q;
    logic [WIDTH-1:0] alu_a_q;
    logic [WIDTH-1:0] alu_b_q;
    logic             alu_mode_q;
    logic [2:0]       alu_oper_q;
    logic             alu_reset_q;
    logic [WIDTH-1:0] res_o_q;
    logic             res_overflow_q;
    logic             res_zero_q;
    logic             sticky_ovf_q;
    logic [CNT_W-1:0] op_count_q;
    logic             have_result_q;

    logic [WIDTH-1:0] alu_a_d;
    logic             res_overflow_d;
    logic [CNT_W-1:0] op_count_d;

    // Chaining only substitutes the previous result once one exists.
    assign alu_a_d        = (in_chain && have_result_q) ? res_o_q : in_a;
    assign res_overflow_d = alu_mode_q ? 1'b0 : alu_overflow;
    assign op_count_d     = op_count_q + CNT_W'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            in_ready_q     <= 1'b1;
            out_valid_q    <= 1'b0;
            alu_a_q        <= '0;
            alu_b_q        <= '0;
            alu_mode_q     <= 1'b0;
            alu_oper_q     <= '0;
            alu_reset_q    <= 1'b1;
            res_o_q        <= '0;
            res_overflow_q <= 1'b0;
            res_zero_q     <= 1'b0;
            sticky_ovf_q   <= 1'b0;
            op_count_q     <= '0;
            have_result_q  <= 1'b0;
        end else begin
            if (clear_sticky) begin
                sticky_ovf_q <= 1'b0;
            end
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        alu_a_q     <= alu_a_d;
                        alu_b_q     <= in_b;
                        alu_mode_q  <= in_op[3];
                        alu_oper_q  <= in_op[2:0];
                        alu_reset_q <= 1'b0;
                        in_ready_q  <= 1'b0;
                        state_q     <= DRIVE;
                    end
                end
                DRIVE: begin
                    state_q <= CAPTURE;
                end
                CAPTURE: begin
                    res_o_q        <= alu_o;
                    res_zero_q     <= alu_zero;
                    res_overflow_q <= res_overflow_d;
                    // A same-edge set overrides clear_sticky above.
                    if (res_overflow_d) begin
                        sticky_ovf_q <= 1'b1;
                    end
                    have_result_q  <= 1'b1;
                    op_count_q     <= op_count_d;
                    alu_reset_q    <= 1'b1;
                    out_valid_q    <= 1'b1;
                    state_q        <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign in_ready     = in_ready_q;
    assign out_valid    = out_valid_q;
    assign alu_a        = alu_a_q;
    assign alu_b        = alu_b_q;
    assign alu_mode     = alu_mode_q;
    assign alu_oper     = alu_oper_q;
    assign alu_reset    = alu_reset_q;
    assign res_o        = res_o_q;
    assign res_overflow = res_overflow_q;
    assign res_zero     = res_zero_q;
    assign sticky_ovf   = sticky_ovf_q;
    assign op_count     = op_count_q;

endmodule

// File: tb/tb_ula_op_sequencer.sv
// Directed bench for ula_op_sequencer with a behavioural 6-bit ULA attached.
module tb_ula_op_sequencer;

    localparam int WIDTH = 6;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [3:0]       in_op;
    logic             in_chain;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic             alu_mode;
    logic [2:0]       alu_oper;
    logic             alu_reset;
    logic [WIDTH-1:0] alu_o;
    logic             alu_overflow;
    logic             alu_zero;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] res_o;
    logic             res_overflow;
    logic             res_zero;
    logic             sticky_ovf;
    logic             clear_sticky;
    logic [CNT_W-1:0] op_count;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    ula_op_sequencer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_chain(in_chain),
        .alu_a(alu_a), .alu_b(alu_b), .alu_mode(alu_mode), .alu_oper(alu_oper),
        .alu_reset(alu_reset), .alu_o(alu_o), .alu_overflow(alu_overflow),
        .alu_zero(alu_zero), .out_valid(out_valid), .out_ready(out_ready),
        .res_o(res_o), .res_overflow(res_overflow), .res_zero(res_zero),
        .sticky_ovf(sticky_ovf), .clear_sticky(clear_sticky), .op_count(op_count)
    );

    // ULA model; logic ops deliberately raise overflow so the sequencer's masking is exercised.
    logic [WIDTH:0] wide;
    always_comb begin
        wide         = '0;
        alu_o        = '0;
        alu_overflow = 1'b0;
        if (!alu_reset) begin
            case ({alu_mode, alu_oper})
                4'b0000: wide = {1'b0, alu_a} + {1'b0, alu_b};
                4'b0001: wide = {1'b0, alu_a} - {1'b0, alu_b};
                4'b1100: wide = {1'b1, alu_a ^ alu_b};
                4'b1101: wide = {1'b1, ~(alu_a & alu_b)};
                default: wide = '0;
            endcase
            alu_o        = wide[WIDTH-1:0];
            alu_overflow = wide[WIDTH];
        end
        alu_zero = (alu_o == '0);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Presents a command at a falling edge; returns at the falling edge after acceptance (DRIVE).
    task automatic issue(input logic [5:0] a, input logic [5:0] b, input logic [3:0] op,
                         input logic chain);
        int n;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("issue_ready", in_ready, 1);
        in_a     = a;
        in_b     = b;
        in_op    = op;
        in_chain = chain;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_done(output int cycles);
        cycles = 0;
        while (!out_valid && cycles < 20) begin
            @(negedge clk);
            cycles++;
        end
    endtask

    task automatic pop();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        int cyc;
        reset = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_op = '0;
        in_chain = 1'b0; out_ready = 1'b0; clear_sticky = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_alu_reset", alu_reset, 1);
        chk("rst_alu_a", alu_a, 0);
        chk("rst_res_o", res_o, 0);
        chk("rst_sticky", sticky_ovf, 0);
        chk("rst_op_count", op_count, 0);

        // ADD 20+30 with latency check
        issue(6'd20, 6'd30, 4'b0000, 1'b0);
        chk("add_drive_ready", in_ready, 0);
        chk("add_drive_alu_reset", alu_reset, 0);
        wait_done(cyc);
        chk("add_latency", cyc, 2);
        chk("add_res", res_o, 50);
        chk("add_ovf", res_overflow, 0);
        chk("add_zero", res_zero, 0);
        chk("add_count", op_count, 1);
        chk("add_done_alu_reset", alu_reset, 1);
        pop();
        chk("add_pop_valid", out_valid, 0);
        chk("add_pop_ready", in_ready, 1);

        // Wrapping add, borrowing sub, sticky clear
        issue(6'd40, 6'd30, 4'b0000, 1'b0);
        wait_done(cyc);
        chk("wrap_res", res_o, 6);
        chk("wrap_ovf", res_overflow, 1);
        chk("wrap_sticky", sticky_ovf, 1);
        pop();
        issue(6'd5, 6'd7, 4'b0001, 1'b0);
        wait_done(cyc);
        chk("sub_res", res_o, 62);
        chk("sub_ovf", res_overflow, 1);
        pop();
        clear_sticky = 1'b1;
        @(negedge clk);
        clear_sticky = 1'b0;
        chk("clear_sticky", sticky_ovf, 0);
        chk("count_3", op_count, 3);

        // Chaining
        issue(6'd5, 6'd3, 4'b0000, 1'b0);
        wait_done(cyc);
        chk("chain_seed", res_o, 8);
        pop();
        issue(6'd63, 6'd8, 4'b0001, 1'b1);
        chk("chain_alu_a", alu_a, 8);
        wait_done(cyc);
        chk("chain_res", res_o, 0);
        chk("chain_zero", res_zero, 1);
        chk("chain_ovf", res_overflow, 0);
        pop();

        // Logic ops with sticky already set
        issue(6'd40, 6'd30, 4'b0000, 1'b0);
        wait_done(cyc);
        pop();
        chk("logic_pre_sticky", sticky_ovf, 1);
        issue(6'h2A, 6'h3F, 4'b1100, 1'b0);
        wait_done(cyc);
        chk("xor_res", res_o, 6'h15);
        chk("xor_ovf", res_overflow, 0);
        chk("xor_sticky", sticky_ovf, 1);
        pop();
        issue(6'h3F, 6'h3F, 4'b1101, 1'b0);
        wait_done(cyc);
        chk("nand_res", res_o, 0);
        chk("nand_zero", res_zero, 1);
        chk("nand_ovf", res_overflow, 0);
        chk("count_8", op_count, 8);
        pop();

        // Backpressure with a command waiting
        issue(6'd1, 6'd2, 4'b0000, 1'b0);
        wait_done(cyc);
        in_a = 6'd10; in_b = 6'd10; in_op = 4'b0000; in_chain = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_valid", out_valid, 1);
            chk("bp_in_ready", in_ready, 0);
            chk("bp_res", res_o, 3);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("bp_release_valid", out_valid, 0);
        chk("bp_release_ready", in_ready, 1);
        chk("bp_count", op_count, 9);
        @(negedge clk);
        in_valid = 1'b0;
        chk("bp_accepted", in_ready, 0);
        wait_done(cyc);
        chk("bp_second_res", res_o, 20);
        chk("bp_second_count", op_count, 10);
        pop();

        // Reset while in DRIVE
        issue(6'd7, 6'd7, 4'b0000, 1'b0);
        chk("mid_in_drive", alu_reset, 0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("mid_out_valid", out_valid, 0);
        chk("mid_alu_reset", alu_reset, 1);
        chk("mid_in_ready", in_ready, 1);
        chk("mid_count", op_count, 0);
        chk("mid_res", res_o, 0);
        issue(6'd9, 6'd1, 4'b0000, 1'b1);
        chk("mid_chain_alu_a", alu_a, 9);
        wait_done(cyc);
        chk("mid_chain_res", res_o, 10);
        chk("mid_chain_count", op_count, 1);
        pop();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
